// File: rtl/hopfield_learn_recall_engine.sv
// Hopfield core: N bipolar neurons, symmetric saturating weight array,
// sequential Hebbian learning and asynchronous-update recall.
module hopfield_learn_recall_engine #(
    parameter int unsigned N        = 8,
    parameter int unsigned WW       = 8,
    parameter int unsigned MAX_ITER = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [1:0]             cmd,
    input  logic [N-1:0]           pattern_in,
    output logic                   busy,
    output logic                   done,
    output logic                   converged,
    output logic [N-1:0]           state_out,
    output logic [7:0]             iter_count,
    input  logic [$clog2(N)-1:0]   rd_row,
    input  logic [$clog2(N)-1:0]   rd_col,
    output logic [WW-1:0]          rd_weight
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned HW = WW + IW + 1;
    localparam logic signed [WW-1:0] W_MAX = {1'b0, {(WW-1){1'b1}}};
    localparam logic signed [WW-1:0] W_MIN = -W_MAX;

    localparam logic [1:0] CMD_CLEAR  = 2'b00;
    localparam logic [1:0] CMD_LEARN  = 2'b01;
    localparam logic [1:0] CMD_RECALL = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LEARN, S_RECALL, S_FIN
    } state_t;

    state_t                 state, state_next;
    logic                   accept;
    logic signed [WW-1:0]   w [N][N];
    logic [N-1:0]           pat_q;
    logic [IW-1:0]          row, col;
    logic                   flip_q;

    logic signed [HW-1:0]   h;
    logic                   h_pos, h_neg, flip_now, any_flip;
    logic                   last_idx, last_pair;
    logic [7:0]             iter_inc;
    logic signed [WW-1:0]   w_cur, w_new;

    // Local field of the neuron under update, skipping the diagonal
    always_comb begin
        h = '0;
        for (int j = 0; j < N; j++) begin
            if (IW'(j) != row) begin
                if (state_out[j]) h = h + HW'(w[row][j]);
                else              h = h - HW'(w[row][j]);
            end
        end
    end

    // Flip detection, loop bounds and saturating Hebbian increment
    always_comb begin
        h_pos     = !h[HW-1] && (h != '0);
        h_neg     = h[HW-1];
        flip_now  = (h_pos && !state_out[row]) || (h_neg && state_out[row]);
        any_flip  = flip_q | flip_now;
        last_idx  = (row == IW'(N-1));
        last_pair = (row == IW'(N-2)) && (col == IW'(N-1));
        iter_inc  = iter_count + 8'd1;
        w_cur     = w[row][col];
        if (pat_q[row] == pat_q[col]) w_new = (w_cur == W_MAX) ? w_cur : w_cur + WW'(1);
        else                          w_new = (w_cur == W_MIN) ? w_cur : w_cur - WW'(1);
    end

    assign rd_weight = w[rd_row][rd_col];

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    // Next-state logic and command acceptance
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && cmd != 2'b11) begin
                    accept = 1'b1;
                    case (cmd)
                        CMD_CLEAR: state_next = S_CLEAR;
                        CMD_LEARN: state_next = S_LEARN;
                        default:   state_next = S_RECALL;
                    endcase
                end
            end
            S_CLEAR:  if (last_idx)  state_next = S_FIN;
            S_LEARN:  if (last_pair) state_next = S_FIN;
            S_RECALL: begin
                if (last_idx && (!any_flip || iter_inc == 8'(MAX_ITER)))
                    state_next = S_FIN;
            end
            S_FIN:    state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Handshake outputs registered from the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next == S_CLEAR) || (state_next == S_LEARN) ||
                    (state_next == S_RECALL);
            done <= (state_next == S_FIN);
        end
    end

    // Datapath: weight array, neuron states, sweep bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    w[r][c] <= '0;
            pat_q      <= '0;
            row        <= '0;
            col        <= '0;
            flip_q     <= 1'b0;
            state_out  <= '0;
            iter_count <= '0;
            converged  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        pat_q     <= pattern_in;
                        row       <= '0;
                        col       <= IW'(1);
                        flip_q    <= 1'b0;
                        converged <= 1'b0;
                        if (cmd == CMD_RECALL) begin
                            state_out  <= pattern_in;
                            iter_count <= '0;
                        end
                    end
                end
                S_CLEAR: begin
                    for (int c = 0; c < N; c++) w[row][c] <= '0;
                    row <= row + IW'(1);
                end
                S_LEARN: begin
                    w[row][col] <= w_new;
                    w[col][row] <= w_new;
                    if (col == IW'(N-1)) begin
                        row <= row + IW'(1);
                        col <= row + IW'(2);
                    end else begin
                        col <= col + IW'(1);
                    end
                end
                S_RECALL: begin
                    if (h_pos)      state_out[row] <= 1'b1;
                    else if (h_neg) state_out[row] <= 1'b0;
                    if (last_idx) begin
                        row        <= '0;
                        flip_q     <= 1'b0;
                        iter_count <= iter_inc;
                        converged  <= !any_flip;
                    end else begin
                        row    <= row + IW'(1);
                        flip_q <= any_flip;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hopfield_learn_recall_engine.sv
// Directed bench for the Hopfield engine (N=4, WW=4; MAX_ITER 4 and 1).
module tb_hopfield_learn_recall_engine;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [1:0] cmd;
    logic [3:0] pattern_in;
    logic [1:0] rd_row, rd_col;

    logic       busy, done, converged;
    logic [3:0] state_out;
    logic [7:0] iter_count;
    logic [3:0] rd_weight;

    logic       busy1, done1, converged1;
    logic [3:0] state_out1;
    logic [7:0] iter_count1;
    logic [3:0] rd_weight1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hopfield_learn_recall_engine #(.N(4), .WW(4), .MAX_ITER(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .cmd(cmd), .pattern_in(pattern_in),
        .busy(busy), .done(done), .converged(converged), .state_out(state_out),
        .iter_count(iter_count), .rd_row(rd_row), .rd_col(rd_col), .rd_weight(rd_weight)
    );

    hopfield_learn_recall_engine #(.N(4), .WW(4), .MAX_ITER(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start), .cmd(cmd), .pattern_in(pattern_in),
        .busy(busy1), .done(done1), .converged(converged1), .state_out(state_out1),
        .iter_count(iter_count1), .rd_row(rd_row), .rd_col(rd_col), .rd_weight(rd_weight1)
    );

    // Issue one command; latency k means done seen in cycle T+k. Inputs are
    // scrambled while busy, and poke re-strobes start mid-command.
    task automatic do_cmd(input logic [1:0] c, input logic [3:0] p, input bit poke,
                          output int lat, output int lat1, output int bcnt);
        @(negedge clk);
        cmd = c; pattern_in = p; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1; lat1 = -1; bcnt = 0;
        for (int k = 1; k <= 100 && lat < 0; k++) begin
            if (k == 2) begin pattern_in = ~p; cmd = 2'b11; end
            if (poke && k == 3) begin start = 1'b1; cmd = 2'b00; end
            if (poke && k == 4) start = 1'b0;
            if (busy) bcnt++;
            if (done1 && lat1 < 0) lat1 = k;
            if (done) lat = k;
            if (lat < 0) @(negedge clk);
        end
        start = 1'b0;
        if (lat < 0) begin
            checks++; errors++;
            $display("FAIL cmd_timeout: cmd=%b got no done, required done within 100 cycles", c);
        end
    endtask

    task automatic read_w(input int r, input int c, output logic [3:0] v, output logic [3:0] v1);
        rd_row = 2'(r); rd_col = 2'(c);
        #1;
        v = rd_weight; v1 = rd_weight1;
    endtask

    task automatic test_reset;
        logic [3:0] v, v1;
        reset_n = 1'b0; start = 1'b0; cmd = 2'b00; pattern_in = 4'h0;
        rd_row = 2'd0; rd_col = 2'd0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, converged} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b required 000", {busy, done, converged});
        end
        checks++;
        if (state_out !== 4'h0 || iter_count !== 8'd0) begin
            errors++; $display("FAIL reset_state: got state=%b iter=%0d required 0000/0", state_out, iter_count);
        end
        read_w(0, 2, v, v1);
        checks++;
        if (v !== 4'h0) begin errors++; $display("FAIL reset_weight: got %h required 0", v); end
    endtask

    task automatic test_clear;
        int lat, lat1, bc, nz;
        logic [3:0] v, v1;
        do_cmd(2'b00, 4'h0, 1'b0, lat, lat1, bc);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL clear_latency: got %0d required 5", lat); end
        checks++;
        if (bc !== 4) begin errors++; $display("FAIL clear_busy_cycles: got %0d required 4", bc); end
        nz = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                read_w(r, c, v, v1);
                if (v !== 4'h0) nz++;
            end
        checks++;
        if (nz !== 0) begin errors++; $display("FAIL clear_weights: got %0d nonzero required 0", nz); end
    endtask

    task automatic test_learn;
        int lat, lat1, bc, bad;
        logic [3:0] v, v1;
        logic [3:0] exp_w [4][4];
        exp_w[0] = '{4'h0, 4'hF, 4'h1, 4'hF};
        exp_w[1] = '{4'hF, 4'h0, 4'hF, 4'h1};
        exp_w[2] = '{4'h1, 4'hF, 4'h0, 4'hF};
        exp_w[3] = '{4'hF, 4'h1, 4'hF, 4'h0};
        do_cmd(2'b01, 4'b0101, 1'b0, lat, lat1, bc);
        checks++;
        if (lat !== 7) begin errors++; $display("FAIL learn_latency: got %0d required 7", lat); end
        bad = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                read_w(r, c, v, v1);
                if (v !== exp_w[r][c]) begin
                    bad++;
                    $display("FAIL learn_w%0d%0d: got %h required %h", r, c, v, exp_w[r][c]);
                end
            end
        checks++;
        if (bad !== 0) errors++;
    endtask

    task automatic test_recall;
        int lat, lat1, bc;
        do_cmd(2'b10, 4'b0001, 1'b0, lat, lat1, bc);
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL recall_latency: got %0d required 9", lat); end
        checks++;
        if (state_out !== 4'b0101 || converged !== 1'b1 || iter_count !== 8'd2) begin
            errors++;
            $display("FAIL recall_result: got state=%b conv=%b iter=%0d required 0101/1/2",
                     state_out, converged, iter_count);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (state_out !== 4'b0101 || iter_count !== 8'd2 || converged !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL recall_hold: got state=%b iter=%0d conv=%b busy=%b required 0101/2/1/0",
                     state_out, iter_count, converged, busy);
        end
    endtask

    task automatic test_saturation;
        int lat, lat1, bc;
        logic [3:0] v, v1;
        do_cmd(2'b00, 4'h0, 1'b0, lat, lat1, bc);
        for (int n = 0; n < 10; n++) do_cmd(2'b01, 4'b0101, 1'b0, lat, lat1, bc);
        read_w(0, 2, v, v1);
        checks++;
        if (v !== 4'h7) begin errors++; $display("FAIL sat_w02: got %h required 7", v); end
        read_w(1, 0, v, v1);
        checks++;
        if (v !== 4'h9) begin errors++; $display("FAIL sat_w10: got %h required 9 (-7)", v); end
        read_w(3, 3, v, v1);
        checks++;
        if (v !== 4'h0) begin errors++; $display("FAIL sat_diag: got %h required 0", v); end
        do_cmd(2'b10, 4'b0101, 1'b0, lat, lat1, bc);
        checks++;
        if (lat !== 5 || iter_count !== 8'd1 || converged !== 1'b1 || state_out !== 4'b0101) begin
            errors++;
            $display("FAIL sat_recall: got lat=%0d iter=%0d conv=%b state=%b required 5/1/1/0101",
                     lat, iter_count, converged, state_out);
        end
    endtask

    task automatic test_max_iter;
        int lat, lat1, bc;
        do_cmd(2'b00, 4'h0, 1'b0, lat, lat1, bc);
        do_cmd(2'b01, 4'b0101, 1'b0, lat, lat1, bc);
        do_cmd(2'b10, 4'b0001, 1'b0, lat, lat1, bc);
        checks++;
        if (lat1 !== 5) begin errors++; $display("FAIL maxiter_latency: got %0d required 5", lat1); end
        checks++;
        if (converged1 !== 1'b0 || iter_count1 !== 8'd1 || state_out1 !== 4'b0101) begin
            errors++;
            $display("FAIL maxiter_result: got conv=%b iter=%0d state=%b required 0/1/0101",
                     converged1, iter_count1, state_out1);
        end
    endtask

    task automatic test_ignored_and_abort;
        int lat, lat1, bc, seen;
        logic [3:0] v, v1;
        do_cmd(2'b00, 4'h0, 1'b0, lat, lat1, bc);
        do_cmd(2'b01, 4'b0011, 1'b1, lat, lat1, bc);
        checks++;
        if (lat !== 7) begin errors++; $display("FAIL ignore_busy_latency: got %0d required 7", lat); end
        read_w(0, 1, v, v1);
        checks++;
        if (v !== 4'h1) begin errors++; $display("FAIL ignore_busy_w01: got %h required 1", v); end
        // Reserved command in IDLE must not start anything
        @(negedge clk);
        cmd = 2'b11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        repeat (4) begin
            if (busy || done) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL reserved_cmd: got %0d active cycles required 0", seen); end
        // Reset in the middle of LEARN
        cmd = 2'b01; pattern_in = 4'b0101; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        read_w(0, 1, v, v1);
        checks++;
        if (v !== 4'h0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_reset: got w01=%h busy=%b required 0/0", v, busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles required 0", seen); end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_learn();
        test_recall();
        test_saturation();
        test_max_iter();
        test_ignored_and_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
